// File: rtl/int_replay_queue_pkg.sv
// Integer replay queue shared types.
// Entry layout, derived widths and flush-range match.
package int_replay_queue_pkg;

    localparam int IRQ_ISSUE_W = 2;
    localparam int IRQ_DEPTH   = 8;
    localparam int IRQ_DATA_W  = 64;
    localparam int IRQ_AL_W    = 6;
    localparam int IRQ_PTR_W   = $clog2(IRQ_DEPTH);
    localparam int IRQ_CNT_W   = IRQ_PTR_W + 1;

    typedef struct packed {
        logic                  live;
        logic [IRQ_DATA_W-1:0] data;
        logic [IRQ_AL_W-1:0]   al_ptr;
    } irq_entry_t;

    // Range is [h, t) on the circular active list; h==t is empty.
    function automatic logic flush_match(
        input logic                fv,
        input logic                fa,
        input logic [IRQ_AL_W-1:0] h,
        input logic [IRQ_AL_W-1:0] t,
        input logic [IRQ_AL_W-1:0] p
    );
        logic hit;
        if (!fv)
            hit = 1'b0;
        else if (fa)
            hit = 1'b1;
        else if (h <= t)
            hit = (p >= h) && (p < t);
        else
            hit = (p >= h) || (p < t);
        return hit;
    endfunction

endpackage

// File: rtl/replay_flush_range_checker.sv
// Flush-range match for every slot, every record lane and the head.
// Purely combinational.
module replay_flush_range_checker
    import int_replay_queue_pkg::*;
#(
    parameter int DEPTH        = IRQ_DEPTH,
    parameter int ISSUE_WIDTH  = IRQ_ISSUE_W,
    parameter int AL_PTR_WIDTH = IRQ_AL_W
) (
    input  logic                                     flush_valid,
    input  logic                                     flush_all,
    input  logic [AL_PTR_WIDTH-1:0]                  flush_head_ptr,
    input  logic [AL_PTR_WIDTH-1:0]                  flush_tail_ptr,
    input  logic [DEPTH-1:0][AL_PTR_WIDTH-1:0]       slot_ptr,
    input  logic [ISSUE_WIDTH-1:0][AL_PTR_WIDTH-1:0] lane_ptr,
    input  logic [AL_PTR_WIDTH-1:0]                  head_ptr,
    output logic [DEPTH-1:0]                         slot_hit,
    output logic [ISSUE_WIDTH-1:0]                   lane_hit,
    output logic                                     head_hit
);

    // Evaluate the same range test against each candidate pointer.
    always_comb begin
        slot_hit = '0;
        lane_hit = '0;
        for (int k = 0; k < DEPTH; k++)
            slot_hit[k] = flush_match(flush_valid, flush_all,
                                      flush_head_ptr, flush_tail_ptr,
                                      slot_ptr[k]);
        for (int i = 0; i < ISSUE_WIDTH; i++)
            lane_hit[i] = flush_match(flush_valid, flush_all,
                                      flush_head_ptr, flush_tail_ptr,
                                      lane_ptr[i]);
        head_hit = flush_match(flush_valid, flush_all,
                               flush_head_ptr, flush_tail_ptr, head_ptr);
    end

endmodule

// File: rtl/int_replay_queue.sv
// Integer replay queue: holds unfinished micro-ops and re-offers them
// to the scheduler in record order, dropping flushed entries.
module int_replay_queue
    import int_replay_queue_pkg::*;
#(
    parameter int ISSUE_WIDTH  = IRQ_ISSUE_W,
    parameter int DEPTH        = IRQ_DEPTH,
    parameter int DATA_WIDTH   = IRQ_DATA_W,
    parameter int AL_PTR_WIDTH = IRQ_AL_W
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [ISSUE_WIDTH-1:0]                   record_valid,
    input  logic [ISSUE_WIDTH-1:0][DATA_WIDTH-1:0]   record_data,
    input  logic [ISSUE_WIDTH-1:0][AL_PTR_WIDTH-1:0] record_al_ptr,
    input  logic                                     flush_valid,
    input  logic                                     flush_all,
    input  logic [AL_PTR_WIDTH-1:0]                  flush_head_ptr,
    input  logic [AL_PTR_WIDTH-1:0]                  flush_tail_ptr,
    input  logic                                     stall,
    input  logic                                     replay_ready,
    output logic                                     replay_valid,
    output logic [DATA_WIDTH-1:0]                    replay_data,
    output logic [AL_PTR_WIDTH-1:0]                  replay_al_ptr,
    output logic [$clog2(DEPTH):0]                   count,
    output logic                                     full,
    output logic                                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    irq_entry_t                             ent [DEPTH];
    logic [PTR_W-1:0]                       head;
    logic [PTR_W-1:0]                       tail;
    logic [CNT_W-1:0]                       cnt;
    logic                                   ovf;

    logic [DEPTH-1:0][AL_PTR_WIDTH-1:0]     slot_ptr;
    logic [DEPTH-1:0]                       slot_hit;
    logic [ISSUE_WIDTH-1:0]                 lane_hit;
    logic                                   head_hit;
    irq_entry_t                             head_e;

    logic                                   pop;
    logic [CNT_W-1:0]                       free;
    logic [CNT_W-1:0]                       acc;
    logic                                   drop;
    logic [ISSUE_WIDTH-1:0]                 wr_en;
    logic [ISSUE_WIDTH-1:0][PTR_W-1:0]      wr_slot;

    // Gather stored pointers for the range checker.
    always_comb begin
        slot_ptr = '0;
        for (int k = 0; k < DEPTH; k++)
            slot_ptr[k] = ent[k].al_ptr;
    end

    assign head_e = ent[head];

    replay_flush_range_checker #(
        .DEPTH        (DEPTH),
        .ISSUE_WIDTH  (ISSUE_WIDTH),
        .AL_PTR_WIDTH (AL_PTR_WIDTH)
    ) u_chk (
        .flush_valid    (flush_valid),
        .flush_all      (flush_all),
        .flush_head_ptr (flush_head_ptr),
        .flush_tail_ptr (flush_tail_ptr),
        .slot_ptr       (slot_ptr),
        .lane_ptr       (record_al_ptr),
        .head_ptr       (head_e.al_ptr),
        .slot_hit       (slot_hit),
        .lane_hit       (lane_hit),
        .head_hit       (head_hit)
    );

    assign replay_valid  = head_e.live && (cnt != '0) && !stall && !head_hit;
    assign replay_data   = head_e.data;
    assign replay_al_ptr = head_e.al_ptr;
    assign count         = cnt;
    assign full          = cnt > CNT_W'(DEPTH - ISSUE_WIDTH);
    assign overflow      = ovf;

    // Dead or flushed heads drain even while stalled.
    assign pop  = (cnt != '0) &&
                  ((replay_valid && replay_ready) || !head_e.live || head_hit);
    assign free = CNT_W'(DEPTH) - cnt + CNT_W'(pop);

    // Pack surviving lanes into consecutive slots from tail.
    always_comb begin
        acc     = '0;
        drop    = 1'b0;
        wr_en   = '0;
        wr_slot = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (record_valid[i] && !lane_hit[i]) begin
                if (acc < free) begin
                    wr_en[i]   = 1'b1;
                    wr_slot[i] = tail + acc[PTR_W-1:0];
                    acc        = acc + 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    // Storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            for (int k = 0; k < DEPTH; k++)
                ent[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++)
                if (ent[k].live && slot_hit[k])
                    ent[k].live <= 1'b0;
            if (pop)
                ent[head].live <= 1'b0;
            for (int i = 0; i < ISSUE_WIDTH; i++)
                if (wr_en[i])
                    ent[wr_slot[i]] <= '{live:   1'b1,
                                         data:   record_data[i],
                                         al_ptr: record_al_ptr[i]};
            if (pop)
                head <= head + 1'b1;
            tail <= tail + acc[PTR_W-1:0];
            cnt  <= cnt + acc - CNT_W'(pop);
            if (drop)
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_int_replay_queue.sv
// Scoreboard bench for int_replay_queue.
// Stimulus pushes expected replays; a negedge monitor pops and compares.
module tb_int_replay_queue;

    typedef struct {
        logic [63:0] d;
        logic [5:0]  p;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       record_valid;
    logic [1:0][63:0] record_data;
    logic [1:0][5:0]  record_al_ptr;
    logic             flush_valid;
    logic             flush_all;
    logic [5:0]       flush_head_ptr;
    logic [5:0]       flush_tail_ptr;
    logic             stall;
    logic             replay_ready;
    logic             replay_valid;
    logic [63:0]      replay_data;
    logic [5:0]       replay_al_ptr;
    logic [3:0]       count;
    logic             full;
    logic             overflow;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    int_replay_queue dut (
        .clk            (clk),
        .rst            (rst),
        .record_valid   (record_valid),
        .record_data    (record_data),
        .record_al_ptr  (record_al_ptr),
        .flush_valid    (flush_valid),
        .flush_all      (flush_all),
        .flush_head_ptr (flush_head_ptr),
        .flush_tail_ptr (flush_tail_ptr),
        .stall          (stall),
        .replay_ready   (replay_ready),
        .replay_valid   (replay_valid),
        .replay_data    (replay_data),
        .replay_al_ptr  (replay_al_ptr),
        .count          (count),
        .full           (full),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rec(input int lane, input logic [63:0] d,
                       input logic [5:0] p, input bit expect_out);
        exp_t e;
        record_valid[lane]  = 1'b1;
        record_data[lane]   = d;
        record_al_ptr[lane] = p;
        if (expect_out) begin
            e.d = d;
            e.p = p;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        record_valid = '0;
        flush_valid  = 1'b0;
        flush_all    = 1'b0;
    endtask

    // Monitor: every accepted replay must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && replay_valid && replay_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_replay: got data %0h ptr %0h expected none",
                         replay_data, replay_al_ptr);
            end else begin
                e = sb.pop_front();
                chk("replay_data", replay_data, e.d);
                chk("replay_al_ptr", {58'd0, replay_al_ptr}, {58'd0, e.p});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b0;
        record_valid   = '0;
        record_data    = '0;
        record_al_ptr  = '0;
        flush_valid    = 1'b0;
        flush_all      = 1'b0;
        flush_head_ptr = '0;
        flush_tail_ptr = '0;
        stall          = 1'b0;
        replay_ready   = 1'b0;
        repeat (2) tick();
        chk("rst_count", 64'(count), 0);
        chk("rst_valid", 64'(replay_valid), 0);
        chk("rst_full", 64'(full), 0);
        chk("rst_ovf", 64'(overflow), 0);
        rst = 1'b1;

        // single record, 1-cycle latency
        replay_ready = 1'b1;
        rec(0, 64'hA5, 6'd3, 1);
        tick();
        idle();
        chk("single_valid", 64'(replay_valid), 1);
        tick();
        chk("single_count", 64'(count), 0);

        // lane ordering
        rec(0, 64'd1, 6'd10, 1);
        rec(1, 64'd2, 6'd11, 1);
        tick();
        idle();
        chk("order_count", 64'(count), 2);
        repeat (2) tick();
        chk("order_drain", 64'(count), 0);

        // wrap-around range flush
        replay_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [5:0] pa;
            logic [5:0] pb;
            pa = 6'(60 + 2 * k);
            pb = 6'(61 + 2 * k);
            rec(0, 64'h100 + 64'(pa), pa, 0);
            rec(1, 64'h100 + 64'(pb), pb, 0);
            tick();
        end
        idle();
        chk("wrap_count", 64'(count), 8);
        chk("wrap_full", 64'(full), 1);
        flush_valid    = 1'b1;
        flush_head_ptr = 6'd62;
        flush_tail_ptr = 6'd2;
        tick();
        idle();
        chk("wrap_count_dead", 64'(count), 8);
        begin
            exp_t e;
            e.d = 64'h100 + 64'd60; e.p = 6'd60; sb.push_back(e);
            e.d = 64'h100 + 64'd61; e.p = 6'd61; sb.push_back(e);
            e.d = 64'h100 + 64'd2;  e.p = 6'd2;  sb.push_back(e);
            e.d = 64'h100 + 64'd3;  e.p = 6'd3;  sb.push_back(e);
        end
        replay_ready = 1'b1;
        repeat (8) tick();
        chk("wrap_drain", 64'(count), 0);
        chk("wrap_sb", 64'(sb.size()), 0);

        // flush_all on the record cycle
        replay_ready = 1'b0;
        rec(0, 64'h77, 6'd5, 0);
        flush_valid = 1'b1;
        flush_all   = 1'b1;
        tick();
        idle();
        chk("recflush_count", 64'(count), 0);
        chk("recflush_valid", 64'(replay_valid), 0);

        // flush of a live head
        rec(0, 64'h88, 6'd7, 0);
        tick();
        idle();
        chk("headflush_pre", 64'(replay_valid), 1);
        flush_valid    = 1'b1;
        flush_head_ptr = 6'd6;
        flush_tail_ptr = 6'd8;
        replay_ready   = 1'b1;
        #1;
        chk("headflush_valid", 64'(replay_valid), 0);
        tick();
        idle();
        chk("headflush_count", 64'(count), 0);

        // full and overflow
        replay_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rec(0, 64'h200 + 64'(2 * k), 6'(2 * k), 1);
            rec(1, 64'h201 + 64'(2 * k), 6'(2 * k + 1), 1);
            tick();
        end
        idle();
        chk("fill_count", 64'(count), 8);
        chk("fill_full", 64'(full), 1);
        chk("fill_ovf", 64'(overflow), 0);
        rec(0, 64'h300, 6'd20, 0);
        rec(1, 64'h301, 6'd21, 0);
        tick();
        idle();
        chk("drop_ovf", 64'(overflow), 1);
        chk("drop_count", 64'(count), 8);
        replay_ready = 1'b1;
        rec(0, 64'h302, 6'd22, 1);
        tick();
        idle();
        chk("poprec_count", 64'(count), 8);
        repeat (8) tick();
        chk("full_drain", 64'(count), 0);
        chk("ovf_sticky", 64'(overflow), 1);
        chk("full_sb", 64'(sb.size()), 0);

        // stall, then reset mid-operation
        stall = 1'b1;
        rec(0, 64'h400, 6'd30, 0);
        rec(1, 64'h401, 6'd31, 0);
        tick();
        idle();
        rec(0, 64'h402, 6'd32, 0);
        tick();
        idle();
        chk("stall_count", 64'(count), 3);
        chk("stall_valid", 64'(replay_valid), 0);
        rst = 1'b0;
        tick();
        rst   = 1'b1;
        stall = 1'b0;
        chk("rst2_count", 64'(count), 0);
        chk("rst2_ovf", 64'(overflow), 0);
        chk("rst2_valid", 64'(replay_valid), 0);
        tick();
        chk("final_sb", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_replay_queue.md
# int_replay_queue

- Buffers integer micro-ops that the integer register-write stage records as not finished (operand data invalid) and hands them back to the scheduler for re-issue, one per cycle, in record order.
- Sits between the register-write stage's record outputs and the scheduler's replay-issue input.
- Discards entries that fall inside an active recovery flush range, both while they wait and on the cycle they are recorded.

## Interface
Parameters:
- ISSUE_WIDTH, 2, record lanes per cycle (integer issue width)
- DEPTH, 8, entries; power of two, at least 2*ISSUE_WIDTH
- DATA_WIDTH, 64, width of the opaque issue-queue payload
- AL_PTR_WIDTH, 6, active-list pointer width

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-low reset
- record_valid  in  [ISSUE_WIDTH]  lane i records an entry
- record_data  in  [ISSUE_WIDTH][DATA_WIDTH]  payload per lane
- record_al_ptr  in  [ISSUE_WIDTH][AL_PTR_WIDTH]  active-list pointer per lane
- flush_valid  in  1  recovery flush active this cycle
- flush_all  in  1  with flush_valid, flush every entry
- flush_head_ptr  in  AL_PTR_WIDTH  flush range start, inclusive
- flush_tail_ptr  in  AL_PTR_WIDTH  flush range end, exclusive
- stall  in  1  back-end stall; suppresses replay output
- replay_ready  in  1  scheduler accepts replay_data
- replay_valid  out  1  head entry offered
- replay_data  out  DATA_WIDTH  head payload
- replay_al_ptr  out  AL_PTR_WIDTH  head pointer
- count  out  $clog2(DEPTH)+1  occupied slots, live and dead
- full  out  1  count > DEPTH-ISSUE_WIDTH
- overflow  out  1  sticky: a record was dropped for lack of space

## Operation
- Storage is a circular buffer with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Each entry holds live, data and al_ptr.
- **Flush match.** Pointer p matches when flush_valid && (flush_all || in range).
  - In range when head<=tail: head<=p<tail.
  - In range when head>tail: p>=head || p<tail.
  - head==tail without flush_all is an empty range.
- **Record.** Valid lanes are packed in ascending lane order into consecutive slots starting at tail.
  - A lane whose al_ptr matches the flush is not written and does not advance tail.
  - A lane is accepted only if a slot is free, counting a pop in the same cycle.
  - A lane rejected for space is dropped and sets overflow.
- **Flush of waiting entries.** Every stored live entry that matches the flush has live cleared at the clock edge.
- **Output.**
  - replay_valid = head live && count!=0 && !stall && !(head al_ptr matches the flush).
  - replay_data and replay_al_ptr always show the head slot.
- **Pop.** The head advances by 1 when either:
  - replay_valid && replay_ready, or
  - the head slot is dead, or
  - the head slot is being flushed this cycle.
  
  Dead entries are never shown on the output.
- **Count.** count_next = count + accepted - pop.

## Timing
- Reset (rst==0 at a rising edge): head=tail=0, count=0, all live=0, overflow=0. Outputs after reset: replay_valid=0, full=0, overflow=0, count=0.
- Reset asserted mid-operation discards all entries in the same edge, whatever else is active.
- Record-to-replay latency is 1 cycle when the queue is empty: record at edge N gives replay_valid high after edge N.
- replay_valid is combinational from state plus stall/flush. replay_ready may depend on replay_valid; there is no combinational path from replay_ready to replay_valid.
- Empty queue with record and pop in the same cycle: no bypass; the entry is output the next cycle.
- Full queue (count==DEPTH) with a pop: one lane is accepted in the same cycle.
- Stall holds all entries. Records and flushes are still processed during stall; dead-head pops continue.
- overflow stays high until reset.

## Structure
- Package int_replay_queue_pkg holds:
  - the entry typedef (live, data, al_ptr);
  - the pointer and count widths derived from DEPTH;
  - the flush-range match function.
- One sub-module, replay_flush_range_checker: combinational, DEPTH+ISSUE_WIDTH+1 match outputs computed from the flush inputs. Instantiated once.
- The compaction of record lanes (prefix count of accepted lanes) stays inline.

## Test plan
- **Single record, no stall.** Record lane0 data=0xA5, al_ptr=3 at cycle 0, replay_ready=1 -> replay_valid=1 with data 0xA5 in cycle 1; count returns to 0 in cycle 2.
- **Lane ordering.** Both lanes record (data 1 then 2) in one cycle -> replayed 1 then 2 on consecutive cycles.
- **Wrap-around range flush.** Eight entries with al_ptr 60,61,62,63,0,1,2,3; flush head=62, tail=2 -> only the entries with al_ptr 60, 61, 2, 3 are replayed, in that order.
- **Flush at record and at head.** flush_all in the same cycle as a record -> nothing stored, count stays 0. Head entry flushed while replay_valid would be 1 -> replay_valid=0 that cycle and the entry is never output.
- **Full and overflow.** DEPTH=8: fill to count=8 with replay_ready=0, then record two lanes -> both dropped, overflow=1. Set replay_ready=1 with one new record -> that record is accepted, count stays 8.
- **Stall and reset.** With stall=1 and the queue holding 3 entries -> replay_valid=0, count=3. Drive rst=0 for one edge -> count=0, overflow=0, replay_valid=0.
